// File: rtl/port_rd_backend.sv
// Per-port read-side egress: buffers SRAM read words in a FIFO and replays them as sop/vld/eop frames.
// Optional per-port packet/word counters are enabled with `define PORT_RD_PKT_CNT_EN.
module port_rd_backend #(
    parameter int DEPTH       = 16,
    parameter int AFULL_SLACK = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     xfer_data_vld,
    input  logic [15:0]              xfer_data,
    input  logic                     end_of_packet,
    output logic                     xfer_ready,
    input  logic                     ready,
    output logic                     rd_sop,
    output logic                     rd_eop,
    output logic                     rd_vld,
    output logic [15:0]              rd_data,
    output logic                     overflow,
`ifdef PORT_RD_PKT_CNT_EN
    output logic [15:0]              pkt_count,
    output logic [15:0]              word_count,
`endif
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, DATA, EOP} state_t;

    state_t          state_q, state_d;
    logic [16:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            xfer_ready_q, xfer_ready_d;
    logic            overflow_q, overflow_d;
    logic            rd_sop_q, rd_sop_d, rd_eop_q, rd_eop_d, rd_vld_q, rd_vld_d;
    logic [15:0]     rd_data_q, rd_data_d;
    logic            full, empty, push, pop;
    logic [16:0]     head;

    always_comb begin
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        push      = xfer_data_vld && !full;
        head      = mem_q[rd_ptr_q];
        pop       = 1'b0;
        state_d   = state_q;
        rd_sop_d  = 1'b0;
        rd_eop_d  = 1'b0;
        rd_vld_d  = 1'b0;
        rd_data_d = rd_data_q;
        unique case (state_q)
            IDLE: begin
                if (ready && !empty) begin
                    rd_sop_d = 1'b1;
                    state_d  = DATA;
                end
            end
            DATA: begin
                // Stalls (ready low or FIFO empty) keep rd_data at its last beat.
                if (ready && !empty) begin
                    pop       = 1'b1;
                    rd_vld_d  = 1'b1;
                    rd_data_d = head[15:0];
                    if (head[16]) state_d = EOP;
                end
            end
            EOP: begin
                rd_eop_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Slack covers SRAM reads already in flight when xfer_ready drops.
        xfer_ready_d = (count_d <= CW'(DEPTH - AFULL_SLACK));
        overflow_d   = overflow_q | (xfer_data_vld && full);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {end_of_packet, xfer_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            xfer_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
            rd_sop_q     <= 1'b0;
            rd_eop_q     <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            xfer_ready_q <= xfer_ready_d;
            overflow_q   <= overflow_d;
            rd_sop_q     <= rd_sop_d;
            rd_eop_q     <= rd_eop_d;
            rd_vld_q     <= rd_vld_d;
            rd_data_q    <= rd_data_d;
        end
    end

`ifdef PORT_RD_PKT_CNT_EN
    logic [15:0] pkt_count_q, pkt_count_d, word_count_q, word_count_d;

    always_comb begin
        pkt_count_d  = rd_eop_q ? pkt_count_q + 16'd1 : pkt_count_q;
        word_count_d = rd_vld_q ? word_count_q + 16'd1 : word_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            pkt_count_q  <= pkt_count_d;
            word_count_q <= word_count_d;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign word_count = word_count_q;
`else
    // Default build: no statistics counters on this port.
`endif

    assign xfer_ready = xfer_ready_q;
    assign rd_sop     = rd_sop_q;
    assign rd_eop     = rd_eop_q;
    assign rd_vld     = rd_vld_q;
    assign rd_data    = rd_data_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_port_rd_backend.sv
// Directed bench for port_rd_backend: framing, backpressure, fill/overflow, back-to-back and mid-packet reset.
module tb_port_rd_backend;
    logic        clk = 1'b0;
    logic        rst, xfer_data_vld, end_of_packet, ready;
    logic [15:0] xfer_data;
    logic        xfer_ready, rd_sop, rd_eop, rd_vld, overflow;
    logic [15:0] rd_data;
    logic [4:0]  fifo_count;
`ifdef PORT_RD_PKT_CNT_EN
    logic [15:0] pkt_count, word_count;
`endif

    int checks = 0;
    int errors = 0;

    port_rd_backend #(.DEPTH(16), .AFULL_SLACK(4)) dut (
        .clk(clk), .rst(rst),
        .xfer_data_vld(xfer_data_vld), .xfer_data(xfer_data), .end_of_packet(end_of_packet),
        .xfer_ready(xfer_ready), .ready(ready),
        .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld), .rd_data(rd_data),
        .overflow(overflow),
`ifdef PORT_RD_PKT_CNT_EN
        .pkt_count(pkt_count), .word_count(word_count),
`endif
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares {sop,vld,eop,data}; data only matters on a valid beat.
    task automatic outv(input string tag, input logic s, input logic v, input logic e, input logic [15:0] d);
        chk(tag, {13'd0, rd_sop, rd_vld, rd_eop, (v ? rd_data : 16'h0)},
                 {13'd0, s, v, e, (v ? d : 16'h0)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic last);
        xfer_data_vld = 1'b1;
        xfer_data     = d;
        end_of_packet = last;
    endtask

    task automatic no_push();
        xfer_data_vld = 1'b0;
        xfer_data     = 16'h0;
        end_of_packet = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ready = 1'b0; no_push();
        tick(); tick();
        chk("rst_xfer_ready", {31'd0, xfer_ready}, 32'd0);
        outv("rst_outputs", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
        chk("rst_count", {27'd0, fifo_count}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_xfer_ready", {31'd0, xfer_ready}, 32'd1);

        // Single packet, ready held high
        ready = 1'b1;
        push(16'h0123, 1'b0); tick();
        outv("t1_c1", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("t1_count_c1", {27'd0, fifo_count}, 32'd1);
        push(16'hAAAA, 1'b0); tick();
        outv("t1_c2_sop", 1'b1, 1'b0, 1'b0, 16'h0);
        push(16'hBBBB, 1'b1); tick();
        no_push();
        outv("t1_c3", 1'b0, 1'b1, 1'b0, 16'h0123); tick();
        outv("t1_c4", 1'b0, 1'b1, 1'b0, 16'hAAAA); tick();
        outv("t1_c5", 1'b0, 1'b1, 1'b0, 16'hBBBB); tick();
        outv("t1_c6_eop", 1'b0, 1'b0, 1'b1, 16'h0); tick();
        outv("t1_c7_idle", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("t1_count_end", {27'd0, fifo_count}, 32'd0);

        // Backpressure after rd_sop
        push(16'h0123, 1'b0); tick();
        push(16'hAAAA, 1'b0); tick();
        outv("t2_sop", 1'b1, 1'b0, 1'b0, 16'h0);
        ready = 1'b0;
        push(16'hBBBB, 1'b1); tick();
        no_push();
        outv("t2_stall1", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("t2_count_peak", {27'd0, fifo_count}, 32'd3);
        chk("t2_data_hold", {16'd0, rd_data}, 32'h0000BBBB);
        tick();
        outv("t2_stall2", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("t2_count_hold", {27'd0, fifo_count}, 32'd3);
        ready = 1'b1;
        tick();
        outv("t2_w0", 1'b0, 1'b1, 1'b0, 16'h0123);
        chk("t2_count_w0", {27'd0, fifo_count}, 32'd2);
        tick();
        outv("t2_w1", 1'b0, 1'b1, 1'b0, 16'hAAAA); tick();
        outv("t2_w2", 1'b0, 1'b1, 1'b0, 16'hBBBB); tick();
        outv("t2_eop", 1'b0, 1'b0, 1'b1, 16'h0); tick();

        // Fill to full with ready low, then one extra word
        ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push(16'h1000 + 16'(i), (i == 15));
            tick();
            if (i == 11) chk("t3_xfer_ready_at12", {31'd0, xfer_ready}, 32'd1);
            if (i == 12) begin
                chk("t3_xfer_ready_at13", {31'd0, xfer_ready}, 32'd0);
                chk("t3_count13", {27'd0, fifo_count}, 32'd13);
            end
            if (i == 15) begin
                chk("t3_count16", {27'd0, fifo_count}, 32'd16);
                chk("t3_no_overflow", {31'd0, overflow}, 32'd0);
            end
            if (i == 16) begin
                chk("t3_overflow", {31'd0, overflow}, 32'd1);
                chk("t3_count_full", {27'd0, fifo_count}, 32'd16);
            end
        end
        no_push();
        ready = 1'b1;
        tick();
        outv("t3_sop", 1'b1, 1'b0, 1'b0, 16'h0);
        for (int j = 0; j < 16; j++) begin
            tick();
            outv($sformatf("t3_beat%0d", j), 1'b0, 1'b1, 1'b0, 16'h1000 + 16'(j));
        end
        tick();
        outv("t3_eop", 1'b0, 1'b0, 1'b1, 16'h0);
        tick();
        outv("t3_idle", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("t3_drained", {27'd0, fifo_count}, 32'd0);
        chk("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

        // Back-to-back two-word packets
        push(16'hA000, 1'b0); tick();
        push(16'hA001, 1'b1); tick();
        outv("t4_sopA", 1'b1, 1'b0, 1'b0, 16'h0);
        push(16'hB000, 1'b0); tick();
        outv("t4_A0", 1'b0, 1'b1, 1'b0, 16'hA000);
        push(16'hB001, 1'b1); tick();
        no_push();
        outv("t4_A1", 1'b0, 1'b1, 1'b0, 16'hA001); tick();
        outv("t4_eopA", 1'b0, 1'b0, 1'b1, 16'h0); tick();
        outv("t4_sopB", 1'b1, 1'b0, 1'b0, 16'h0); tick();
        outv("t4_B0", 1'b0, 1'b1, 1'b0, 16'hB000); tick();
        outv("t4_B1", 1'b0, 1'b1, 1'b0, 16'hB001); tick();
        outv("t4_eopB", 1'b0, 1'b0, 1'b1, 16'h0); tick();
        outv("t4_idle", 1'b0, 1'b0, 1'b0, 16'h0);

        // Reset after two of four words emitted
        push(16'hC000, 1'b0); tick();
        push(16'hC001, 1'b0); tick();
        push(16'hC002, 1'b0); tick();
        outv("t5_C0", 1'b0, 1'b1, 1'b0, 16'hC000);
        push(16'hC003, 1'b1); tick();
        no_push();
        outv("t5_C1", 1'b0, 1'b1, 1'b0, 16'hC001);
        rst = 1'b1;
        tick();
        outv("t5_rst_outputs", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("t5_rst_data", {16'd0, rd_data}, 32'd0);
        chk("t5_rst_count", {27'd0, fifo_count}, 32'd0);
        chk("t5_rst_overflow", {31'd0, overflow}, 32'd0);
        chk("t5_rst_xfer_ready", {31'd0, xfer_ready}, 32'd0);
        rst = 1'b0;
        tick();
        outv("t5_no_eop", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("t5_xfer_ready_back", {31'd0, xfer_ready}, 32'd1);
        push(16'hD000, 1'b1); tick();
        no_push();
        outv("t5_wait", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("t5_count1", {27'd0, fifo_count}, 32'd1);
        tick();
        outv("t5_sop", 1'b1, 1'b0, 1'b0, 16'h0); tick();
        outv("t5_D0", 1'b0, 1'b1, 1'b0, 16'hD000); tick();
        outv("t5_eop", 1'b0, 1'b0, 1'b1, 16'h0); tick();

`ifdef PORT_RD_PKT_CNT_EN
        begin
            logic [15:0] pc0, wc0;
            pc0 = pkt_count;
            wc0 = word_count;
            for (int p = 0; p < 3; p++) begin
                for (int w = 0; w < 5; w++) begin
                    push(16'hE000 + 16'(p * 16 + w), (w == 4));
                    tick();
                end
            end
            no_push();
            repeat (20) tick();
            chk("cnt_pkts", {16'd0, 16'(pkt_count - pc0)}, 32'd3);
            chk("cnt_words", {16'd0, 16'(word_count - wc0)}, 32'd15);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
